// File: rtl/bgr_startup_seq_pkg.sv
// bgr_seq_pkg: shared state encoding and counter sizing for the bandgap start-up sequencer
package bgr_seq_pkg;
  typedef enum logic [2:0] {IDLE, KICK, SETTLE, CHECK, READY, FAULT} state_e;
  function automatic int cnt_w(input int k, input int s, input int r, input int d);
    int m;
    m = k;
    if (s > m) m = s;
    if (r + 1 > m) m = r + 1;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/bgr_startup_seq_if.sv
// bgr_startup_seq_if: power-management side bus of the bandgap start-up sequencer
interface bgr_startup_seq_if #(
  parameter int NUM_CH = 4,
  parameter int TRIM_W = 4
);
  logic                     en_i;
  logic [NUM_CH*TRIM_W-1:0] trim_i;
  logic [NUM_CH-1:0]        vbg_ok_i;
  logic [NUM_CH-1:0]        porst_o;
  logic [NUM_CH*TRIM_W-1:0] trim_o;
  logic [NUM_CH-1:0]        ready_o;
  logic [NUM_CH-1:0]        fault_o;
  logic                     all_ready_o;
  logic                     any_fault_o;
  modport master (output en_i, trim_i, vbg_ok_i,
                  input porst_o, trim_o, ready_o, fault_o, all_ready_o, any_fault_o);
  modport slave (input en_i, trim_i, vbg_ok_i,
                 output porst_o, trim_o, ready_o, fault_o, all_ready_o, any_fault_o);
endinterface

// File: rtl/bgr_startup_seq_ch.sv
// bgr_ch_seq: one bandgap channel -- ok synchronizer, kick/settle/check FSM, retry and drop supervision, trim latch
module bgr_ch_seq
  import bgr_seq_pkg::*;
#(
  parameter int TRIM_W     = 4,
  parameter int KICK_CYC   = 4,
  parameter int SETTLE_CYC = 16,
  parameter int MAX_RETRY  = 3,
  parameter int DROP_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [TRIM_W-1:0] trim,
  input  logic              vbg_ok,
  output logic              porst,
  output logic [TRIM_W-1:0] trim_q,
  output logic              ready,
  output logic              fault
);
  localparam int CW = cnt_w(KICK_CYC, SETTLE_CYC, MAX_RETRY, DROP_CYC);
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  logic [1:0]    sync;
  logic          ok;
  state_e        st, nx;
  logic [CW-1:0] cnt, cnt_nx, rty, rty_nx;
  assign ok = sync[1];
  // cnt times KICK/SETTLE and counts consecutive low-ok cycles in READY
  always_comb begin
    nx     = st;
    cnt_nx = inc(cnt);
    rty_nx = rty;
    if (!en) begin
      nx     = IDLE;
      cnt_nx = '0;
      rty_nx = '0;
    end else begin
      case (st)
        IDLE: begin
          nx     = KICK;
          cnt_nx = '0;
          rty_nx = '0;
        end
        KICK: if (cnt == CW'(KICK_CYC - 1)) begin
          nx     = SETTLE;
          cnt_nx = '0;
        end
        SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) begin
          nx     = CHECK;
          cnt_nx = '0;
        end
        CHECK: begin
          rty_nx = inc(rty);
          cnt_nx = '0;
          nx     = ok ? READY : (inc(rty) == CW'(MAX_RETRY) ? FAULT : KICK);
        end
        READY: begin
          cnt_nx = ok ? '0 : inc(cnt);
          if (!ok && inc(cnt) == CW'(DROP_CYC)) begin
            nx     = KICK;
            cnt_nx = '0;
            rty_nx = '0;
          end
        end
        FAULT: cnt_nx = cnt;
        default: begin
          nx     = IDLE;
          cnt_nx = '0;
          rty_nx = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      st     <= IDLE;
      cnt    <= '0;
      rty    <= '0;
      trim_q <= '0;
      porst  <= 1'b0;
      ready  <= 1'b0;
      fault  <= 1'b0;
    end else begin
      sync   <= {sync[0], vbg_ok};
      st     <= nx;
      cnt    <= cnt_nx;
      rty    <= rty_nx;
      trim_q <= (st == IDLE && en) ? trim : trim_q;
      porst  <= nx == KICK;
      ready  <= nx == READY;
      fault  <= nx == FAULT;
    end
  end
endmodule

// File: rtl/bgr_startup_seq.sv
// bgr_startup_seq: NUM_CH independent bandgap start-up sequencers plus registered summary flags
module bgr_startup_seq
  import bgr_seq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int TRIM_W     = 4,
  parameter int KICK_CYC   = 4,
  parameter int SETTLE_CYC = 16,
  parameter int MAX_RETRY  = 3,
  parameter int DROP_CYC   = 2
) (
  input logic               clk,
  input logic               rst_n,
  bgr_startup_seq_if.slave  bus
);
  logic [NUM_CH-1:0]        porst, ready, fault;
  logic [NUM_CH*TRIM_W-1:0] trim;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bgr_ch_seq #(
      .TRIM_W(TRIM_W), .KICK_CYC(KICK_CYC), .SETTLE_CYC(SETTLE_CYC),
      .MAX_RETRY(MAX_RETRY), .DROP_CYC(DROP_CYC)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(bus.en_i),
      .trim(bus.trim_i[i*TRIM_W +: TRIM_W]),
      .vbg_ok(bus.vbg_ok_i[i]),
      .porst(porst[i]),
      .trim_q(trim[i*TRIM_W +: TRIM_W]),
      .ready(ready[i]),
      .fault(fault[i])
    );
  end
  assign bus.porst_o = porst;
  assign bus.trim_o  = trim;
  assign bus.ready_o = ready;
  assign bus.fault_o = fault;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.all_ready_o <= 1'b0;
      bus.any_fault_o <= 1'b0;
    end else begin
      bus.all_ready_o <= &ready;
      bus.any_fault_o <= |fault;
    end
  end
endmodule

// File: tb/tb_bgr_startup_seq.sv
// tb_bgr_startup_seq: directed start-up, retry/fault, drop re-kick, trim, abort and async-reset checks
module tb_bgr_startup_seq;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bgr_startup_seq_if #(.NUM_CH(4), .TRIM_W(4)) bus ();
  bgr_startup_seq #(
    .NUM_CH(4), .TRIM_W(4), .KICK_CYC(4), .SETTLE_CYC(16), .MAX_RETRY(3), .DROP_CYC(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n        = 1'b0;
    bus.en_i     = 1'b0;
    bus.trim_i   = 16'hA5C3;
    bus.vbg_ok_i = 4'hF;
    tick(3);
    chk("rst_porst", 32'(bus.porst_o), 32'h0);
    chk("rst_ready", 32'(bus.ready_o), 32'h0);
    chk("rst_fault", 32'(bus.fault_o), 32'h0);
    chk("rst_trim", 32'(bus.trim_o), 32'h0);
    chk("rst_flags", {30'd0, bus.all_ready_o, bus.any_fault_o}, 32'h0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_porst", 32'(bus.porst_o), 32'h0);
    // start-up with all comparators ok
    bus.en_i = 1'b1;
    tick(1);
    chk("kick_start", 32'(bus.porst_o), 32'hF);
    chk("trim_load", 32'(bus.trim_o), 32'hA5C3);
    tick(3);
    chk("kick_last", 32'(bus.porst_o), 32'hF);
    tick(1);
    chk("kick_end", 32'(bus.porst_o), 32'h0);
    bus.trim_i = 16'h0000;
    tick(16);
    chk("ready_early", 32'(bus.ready_o), 32'h0);
    tick(1);
    chk("ready_on", 32'(bus.ready_o), 32'hF);
    chk("all_ready_lag", 32'(bus.all_ready_o), 32'h0);
    tick(1);
    chk("all_ready_on", 32'(bus.all_ready_o), 32'h1);
    chk("trim_hold", 32'(bus.trim_o), 32'hA5C3);
    // single-cycle glitch on ch0 must not re-kick
    bus.vbg_ok_i = 4'hE;
    tick(1);
    bus.vbg_ok_i = 4'hF;
    tick(5);
    chk("glitch_ready", 32'(bus.ready_o), 32'hF);
    chk("glitch_porst", 32'(bus.porst_o), 32'h0);
    // two synced low cycles trigger a re-kick
    bus.vbg_ok_i = 4'hE;
    tick(2);
    bus.vbg_ok_i = 4'hF;
    tick(1);
    chk("drop_wait", 32'(bus.ready_o), 32'hF);
    tick(1);
    chk("drop_ready", 32'(bus.ready_o), 32'hE);
    chk("drop_kick", 32'(bus.porst_o), 32'h1);
    tick(3);
    chk("drop_kick_last", 32'(bus.porst_o), 32'h1);
    tick(1);
    chk("drop_kick_end", 32'(bus.porst_o), 32'h0);
    tick(16);
    chk("rekick_early", 32'(bus.ready_o), 32'hE);
    tick(1);
    chk("rekick_ready", 32'(bus.ready_o), 32'hF);
    // disable, then ch2 never comes up
    bus.en_i = 1'b0;
    tick(1);
    chk("dis_ready", 32'(bus.ready_o), 32'h0);
    chk("dis_trim", 32'(bus.trim_o), 32'hA5C3);
    bus.vbg_ok_i = 4'hB;
    bus.trim_i   = 16'h5A3C;
    bus.en_i     = 1'b1;
    tick(1);
    chk("f_kick1", 32'(bus.porst_o), 32'hF);
    chk("f_trim", 32'(bus.trim_o), 32'h5A3C);
    tick(4);
    chk("f_kick1_end", 32'(bus.porst_o), 32'h0);
    tick(17);
    chk("f_kick2", 32'(bus.porst_o), 32'h4);
    chk("f_ready_part", 32'(bus.ready_o), 32'hB);
    tick(4);
    chk("f_kick2_end", 32'(bus.porst_o), 32'h0);
    tick(17);
    chk("f_kick3", 32'(bus.porst_o), 32'h4);
    tick(20);
    chk("f_not_yet", 32'(bus.fault_o), 32'h0);
    tick(1);
    chk("f_fault", 32'(bus.fault_o), 32'h4);
    chk("f_ready", 32'(bus.ready_o), 32'hB);
    chk("f_any_lag", 32'(bus.any_fault_o), 32'h0);
    tick(1);
    chk("f_any", 32'(bus.any_fault_o), 32'h1);
    chk("f_all", 32'(bus.all_ready_o), 32'h0);
    chk("f_porst", 32'(bus.porst_o), 32'h0);
    tick(10);
    chk("f_sticky", 32'(bus.fault_o), 32'h4);
    // abort mid-kick
    bus.en_i = 1'b0;
    tick(1);
    chk("clr_fault", 32'(bus.fault_o), 32'h0);
    tick(1);
    chk("clr_any", 32'(bus.any_fault_o), 32'h0);
    bus.vbg_ok_i = 4'hF;
    bus.en_i     = 1'b1;
    tick(2);
    bus.en_i = 1'b0;
    tick(1);
    chk("abort_porst", 32'(bus.porst_o), 32'h0);
    chk("abort_flags", {bus.ready_o, bus.fault_o}, 32'h0);
    bus.en_i = 1'b1;
    tick(1);
    chk("re_kick", 32'(bus.porst_o), 32'hF);
    tick(3);
    chk("re_kick_last", 32'(bus.porst_o), 32'hF);
    tick(1);
    chk("re_kick_end", 32'(bus.porst_o), 32'h0);
    tick(16);
    chk("re_ready_early", 32'(bus.ready_o), 32'h0);
    tick(1);
    chk("re_ready", 32'(bus.ready_o), 32'hF);
    // asynchronous reset mid-settle
    bus.en_i = 1'b0;
    tick(1);
    bus.en_i = 1'b1;
    tick(7);
    chk("pre_rst_trim", 32'(bus.trim_o), 32'h5A3C);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_trim", 32'(bus.trim_o), 32'h0);
    chk("arst_out", {bus.porst_o, bus.ready_o, bus.fault_o, 2'b00, bus.all_ready_o, bus.any_fault_o}, 32'h0);
    bus.trim_i = 16'h1234;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_kick", 32'(bus.porst_o), 32'hF);
    chk("post_rst_trim", 32'(bus.trim_o), 32'h1234);
    tick(20);
    chk("post_rst_early", 32'(bus.ready_o), 32'h0);
    tick(1);
    chk("post_rst_ready", 32'(bus.ready_o), 32'hF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
